// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter, fetches one instruction at a time
// over a req/gnt/rvalid memory port, and hands it to decode with valid/ready.
// Branch/jump redirects are accepted in any state; an in-flight or held
// fetch is discarded when they arrive.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter int unsigned           OPCODE_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction memory port
  output logic                    imem_req,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  // control-flow redirect
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  // decode handshake
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic [5:0]              out_funct
);

  // REQ : request presented at pc_q, waiting for grant
  // WAIT: granted, waiting for the response that will be kept
  // DROP: one response still owed by memory but it is stale; swallow it
  // HOLD: instruction presented to decode, waiting for out_ready
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [31:0]           out_instr_q, out_instr_d;

  logic [ADDR_WIDTH-1:0] redirect_tgt;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  unused_redirect_lsbs;

  // Targets are forced word aligned; the low bits are deliberately dropped.
  assign redirect_tgt         = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  // Natural modulo-2^ADDR_WIDTH wrap of the sequential fetch address.
  assign pc_inc               = pc_q + ADDR_WIDTH'(4);

  // Next-state, PC and output-register update for the fetch FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;

    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          // A grant in the same cycle means memory now owes us a stale word.
          state_d = imem_gnt ? ST_DROP : ST_REQ;
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          out_instr_d = imem_rdata;
          out_pc_d    = pc_q;
          pc_d        = pc_inc;
          state_d     = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_rvalid)    state_d = ST_REQ;
      end
      ST_HOLD: begin
        // Redirect wins over out_ready: the held instruction is killed.
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = ST_REQ;
        end else if (out_ready) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  // The reset state is REQ, but no request may be raised while reset is held.
  assign imem_req   = rst_n & (state_q == ST_REQ);
  assign imem_addr  = pc_q;
  assign out_valid  = (state_q == ST_HOLD);
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;
  assign out_opcode = out_instr_q[31 -: OPCODE_WIDTH];
  assign out_funct  = out_instr_q[5:0];

endmodule
